sys_pll_clkgen: RTL and testbench
=================================

# sys_pll_clkgen

Behavioural, synthesizable PLL model for simulation and FPGA bring-up. It replaces a pass-through clock stub with a parametrised multi-channel generator. From the single system clock it produces, per output channel, a clock-enable strobe and a divided square wave, each with a run-time divisor. It also models lock acquisition with a programmable lock delay, power-down and re-lock on divisor reprogramming. It sits at the top of the clock/reset tree and feeds the reset sequencer (`o_locked`) and the divided-rate domains (`o_clk_en`).

## Interface
- `CHAN_NUM`, default 2: number of output channels, 1..8.
- `DIV_WIDTH`, default 8: divisor width per channel.
- `LOCK_CYCLES`, default 16: clock edges from lock start to `o_locked`; must be >= 1.
- `i_clk` in 1: system clock; the only clock.
- `i_nrst` in 1: reset, asynchronous, active-low.
- `i_pd` in 1: power-down request, level, synchronous.
- `i_div_upd` in 1: single-cycle request to reprogram the divisors and re-lock.
- `i_div` in CHAN_NUM*DIV_WIDTH: divisors; channel k occupies bits [k*DIV_WIDTH +: DIV_WIDTH].
- `o_locked` out 1: lock indication, registered.
- `o_clk_en` out CHAN_NUM: per-channel one-cycle enable strobe.
- `o_clk_div` out CHAN_NUM: per-channel divided clock, period 2*div cycles, registered.

## Operation
- FSM states: PD, LOCKING, LOCKED. Async reset puts it in LOCKING with lock_cnt=0.
- PD:
  - `o_locked`=0; all channel counters, `o_clk_en` and `o_clk_div` held at 0.
  - `i_pd`=0 moves to LOCKING with lock_cnt=0.
- LOCKING:
  - div_r[k] loads from `i_div` on every edge; a value of 0 is stored as 1.
  - lock_cnt increments each edge. When lock_cnt==LOCK_CYCLES-1: go to LOCKED, set `o_locked`=1, clear channel counters.
  - lock_cnt width is $clog2(LOCK_CYCLES+1).
- LOCKED:
  - div_r is frozen.
  - cnt[k] counts 0..div_r[k]-1 and wraps to 0.
  - `o_clk_en[k]` = locked & (cnt[k]==div_r[k]-1). This is decoded from registers only; there is no input-to-output combinational path.
  - `o_clk_div[k]` toggles on every edge where `o_clk_en[k]`=1.
  - div=1 gives `o_clk_en` high every cycle and `o_clk_div` toggling every cycle.
- `i_div_upd`=1 in LOCKED: go to LOCKING with lock_cnt=0. `o_locked`, `o_clk_en` and `o_clk_div` go to 0 on the same edge, and the new divisors are captured during LOCKING.
- `i_div_upd` in PD or LOCKING is ignored.
- `i_pd`=1 in any state: go to PD on the next edge. If asserted together with `i_div_upd`, `i_pd` wins.
- Divisor arithmetic is unsigned DIV_WIDTH. The maximum divisor is 2^DIV_WIDTH-1, and the counter compare must not overflow.

## Timing
- Reset values: `o_locked`=0, `o_clk_en`=0, `o_clk_div`=0, state=LOCKING, lock_cnt=0, cnt=0, div_r=1.
- Lock latency: `o_locked` rises after exactly LOCK_CYCLES rising edges, counted from reset release or from PD/`i_div_upd` exit.
- First strobe: `o_clk_en[k]` is first high in the div_r[k]-th cycle with `o_locked`=1 (cycles counted from 1). Subsequent strobes follow every div_r[k] cycles.
- `o_clk_div[k]`:
  - first rises on the edge ending that first strobe cycle;
  - duty is 50% for every divisor, since each half-period lasts div cycles.
- Unlock latency: 1 edge after `i_pd` or `i_div_upd` is sampled high.
- Reset mid-operation: asynchronous clear of all outputs, independent of `i_clk`.
- `i_div` changes while LOCKED have no effect on the outputs.

## Test plan
- Reset release, LOCK_CYCLES=16, `i_div`={3,1} → `o_locked` high after 16 edges. Ch1 `o_clk_en` high every cycle from then on. Ch0 strobe in locked cycles 3, 6, 9…, with `o_clk_div[0]` period 6.
- `i_div`=0 on ch0 → behaves as div=1; no X and no stuck counter. `i_div`=255 (DIV_WIDTH=8) → strobe every 255 cycles.
- `i_div_upd` pulse while locked, with new `i_div`={5,2} → `o_locked`/`o_clk_en`/`o_clk_div` drop 1 edge later. Re-lock 16 edges after that, then ch0 period 5 and ch1 period 2.
- `i_pd` and `i_div_upd` high in the same cycle → PD entered and outputs held at 0. Releasing `i_pd` → re-lock after 16 edges.
- `i_nrst` asserted mid-period, asynchronously between edges → all outputs go to 0 immediately. After release, the lock sequence restarts at 16 edges.
- `i_div` toggled randomly while LOCKED for 1000 cycles → strobe spacing stays constant; all checked by a scoreboard.

Source files
------------

// File: rtl/sys_pll_clkgen_if.sv
// rtl/sys_pll_clkgen_if.sv - control and clock-output bundle of the behavioural PLL
interface sys_pll_clkgen_if #(
  parameter int CHAN_NUM  = 2,
  parameter int DIV_WIDTH = 8
);
  logic                          i_pd;
  logic                          i_div_upd;
  logic [CHAN_NUM*DIV_WIDTH-1:0] i_div;
  logic                          o_locked;
  logic [CHAN_NUM-1:0]           o_clk_en;
  logic [CHAN_NUM-1:0]           o_clk_div;

  modport master (
    output i_pd, i_div_upd, i_div,
    input  o_locked, o_clk_en, o_clk_div
  );

  modport slave (
    input  i_pd, i_div_upd, i_div,
    output o_locked, o_clk_en, o_clk_div
  );
endinterface

// File: rtl/sys_pll_clkgen.sv
// rtl/sys_pll_clkgen.sv - behavioural PLL: lock sequencing and per-channel clock-enable/divided-clock generation
module sys_pll_clkgen #(
  parameter int CHAN_NUM    = 2,
  parameter int DIV_WIDTH   = 8,
  parameter int LOCK_CYCLES = 16
) (
  input logic             i_clk,
  input logic             i_nrst,
  sys_pll_clkgen_if.slave bus
);
  localparam int LCW = $clog2(LOCK_CYCLES + 1);

  typedef enum logic [1:0] {
    ST_PD,
    ST_LOCKING,
    ST_LOCKED
  } state_t;

  state_t               state;
  state_t               state_n;
  logic [LCW-1:0]       lock_cnt;
  logic                 lock_done;
  logic                 locked;
  logic [DIV_WIDTH-1:0] div_r [CHAN_NUM];
  logic [DIV_WIDTH-1:0] cnt   [CHAN_NUM];
  logic [CHAN_NUM-1:0]  clk_en;
  logic [CHAN_NUM-1:0]  clk_div;

  assign lock_done = (lock_cnt == LCW'(LOCK_CYCLES - 1));

  always_ff @(posedge i_clk or negedge i_nrst) begin
    if (!i_nrst) begin
      state <= ST_LOCKING;
    end else begin
      state <= state_n;
    end
  end

  // Power-down overrides everything, including a same-cycle divisor update.
  always_comb begin
    state_n = state;
    if (bus.i_pd) begin
      state_n = ST_PD;
    end else begin
      case (state)
        ST_PD:      state_n = ST_LOCKING;
        ST_LOCKING: if (lock_done) state_n = ST_LOCKED;
        ST_LOCKED:  if (bus.i_div_upd) state_n = ST_LOCKING;
        default:    state_n = ST_LOCKING;
      endcase
    end
  end

  always_ff @(posedge i_clk or negedge i_nrst) begin
    if (!i_nrst) begin
      lock_cnt <= '0;
      locked   <= 1'b0;
      clk_div  <= '0;
      for (int k = 0; k < CHAN_NUM; k++) begin
        div_r[k] <= DIV_WIDTH'(1);
        cnt[k]   <= '0;
      end
    end else begin
      locked   <= (state_n == ST_LOCKED);
      lock_cnt <= (state == ST_LOCKING && state_n == ST_LOCKING) ? lock_cnt + 1'b1 : '0;
      for (int k = 0; k < CHAN_NUM; k++) begin
        // A zero divisor would make the wrap compare underflow, so it is stored as 1.
        if (state == ST_LOCKING) begin
          div_r[k] <= (bus.i_div[k*DIV_WIDTH +: DIV_WIDTH] == '0) ?
                      DIV_WIDTH'(1) : bus.i_div[k*DIV_WIDTH +: DIV_WIDTH];
        end
        if (state == ST_LOCKED && state_n == ST_LOCKED) begin
          cnt[k]     <= clk_en[k] ? '0 : cnt[k] + 1'b1;
          clk_div[k] <= clk_div[k] ^ clk_en[k];
        end else begin
          cnt[k]     <= '0;
          clk_div[k] <= 1'b0;
        end
      end
    end
  end

  always_comb begin
    clk_en = '0;
    for (int k = 0; k < CHAN_NUM; k++) begin
      clk_en[k] = locked && (cnt[k] == div_r[k] - DIV_WIDTH'(1));
    end
  end

  assign bus.o_locked  = locked;
  assign bus.o_clk_en  = clk_en;
  assign bus.o_clk_div = clk_div;
endmodule

// File: tb/tb_sys_pll_clkgen.sv
// tb/tb_sys_pll_clkgen.sv - self-checking bench for sys_pll_clkgen against a time-index reference model
module tb_sys_pll_clkgen;
  localparam int CN = 2;
  localparam int DW = 8;
  localparam int LC = 16;

  logic clk = 1'b0;
  logic nrst;
  always #5 clk = ~clk;

  sys_pll_clkgen_if #(.CHAN_NUM(CN), .DIV_WIDTH(DW)) bus ();

  sys_pll_clkgen #(.CHAN_NUM(CN), .DIV_WIDTH(DW), .LOCK_CYCLES(LC)) dut (
    .i_clk  (clk),
    .i_nrst (nrst),
    .bus    (bus)
  );

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model: m_t is the 1-based index of the current locked cycle (0 = not locked).
  bit m_pd;
  int m_since;
  int m_t;
  int m_div [CN];

  task automatic model_reset();
    m_pd    = 1'b0;
    m_since = 0;
    m_t     = 0;
    for (int k = 0; k < CN; k++) m_div[k] = 1;
  endtask

  function automatic logic [2*CN:0] exp_out();
    logic [CN-1:0] en;
    logic [CN-1:0] cd;
    for (int k = 0; k < CN; k++) begin
      en[k] = (m_t > 0) && (m_t % m_div[k] == 0);
      cd[k] = (m_t > 0) && ((((m_t - 1) / m_div[k]) % 2) == 1);
    end
    return {(m_t > 0), cd, en};
  endfunction

  function automatic logic [2*CN:0] act_out();
    return {bus.o_locked, bus.o_clk_div, bus.o_clk_en};
  endfunction

  task automatic step();
    int v;
    @(posedge clk);
    if (bus.i_pd) begin
      m_pd = 1'b1; m_since = 0; m_t = 0;
    end else if (m_pd) begin
      m_pd = 1'b0; m_since = 0;
    end else if (m_t > 0) begin
      if (bus.i_div_upd) begin m_t = 0; m_since = 0; end
      else m_t++;
    end else begin
      for (int k = 0; k < CN; k++) begin
        v = int'(bus.i_div[k*DW +: DW]);
        m_div[k] = (v == 0) ? 1 : v;
      end
      m_since++;
      if (m_since == LC) m_t = 1;
    end
    @(negedge clk);
  endtask

  task automatic test_reset();
    nrst = 1'b0;
    bus.i_pd = 1'b0;
    bus.i_div_upd = 1'b0;
    bus.i_div = {8'd1, 8'd3};
    model_reset();
    repeat (3) @(negedge clk);
    n_checks++;
    if (act_out() !== '0)
      $display("FAIL reset_state: got %b expected %b", act_out(), {(2*CN+1){1'b0}});
    nrst = 1'b1;
  endtask

  task automatic test_lock_basic();
    int edges;
    edges = 0;
    while (bus.o_locked !== 1'b1 && edges < 64) begin
      step();
      edges++;
      n_checks++;
      if (act_out() !== exp_out()) begin
        n_fail++;
        $display("FAIL lock_seq edge %0d: got %b expected %b", edges, act_out(), exp_out());
      end
    end
    n_checks++;
    if (edges != LC) begin
      n_fail++;
      $display("FAIL lock_latency: got %0d edges expected %0d", edges, LC);
    end
    for (int i = 0; i < 30; i++) begin
      step();
      n_checks++;
      if (act_out() !== exp_out()) begin
        n_fail++;
        $display("FAIL div_3_1 cyc %0d: got %b expected %b", i, act_out(), exp_out());
      end
    end
  endtask

  task automatic test_div_zero_max();
    bus.i_div = {8'd255, 8'd0};
    bus.i_div_upd = 1'b1;
    step();
    bus.i_div_upd = 1'b0;
    n_checks++;
    if (act_out() !== '0) begin
      n_fail++;
      $display("FAIL upd_unlock: got %b expected %b", act_out(), {(2*CN+1){1'b0}});
    end
    for (int i = 0; i < LC + 560; i++) begin
      step();
      n_checks++;
      if (act_out() !== exp_out()) begin
        n_fail++;
        $display("FAIL div_0_255 cyc %0d: got %b expected %b", i, act_out(), exp_out());
      end
    end
  endtask

  task automatic test_div_upd();
    bus.i_div = {8'd2, 8'd5};
    bus.i_div_upd = 1'b1;
    step();
    bus.i_div_upd = 1'b0;
    for (int i = 0; i < LC + 40; i++) begin
      n_checks++;
      if (act_out() !== exp_out()) begin
        n_fail++;
        $display("FAIL div_upd_5_2 cyc %0d: got %b expected %b", i, act_out(), exp_out());
      end
      step();
    end
  endtask

  task automatic test_pd_and_upd();
    bus.i_pd = 1'b1;
    bus.i_div_upd = 1'b1;
    step();
    bus.i_div_upd = 1'b0;
    for (int i = 0; i < 8; i++) begin
      n_checks++;
      if (act_out() !== '0 || exp_out() !== '0) begin
        n_fail++;
        $display("FAIL pd_hold cyc %0d: got %b expected %b", i, act_out(), {(2*CN+1){1'b0}});
      end
      step();
    end
    bus.i_pd = 1'b0;
    for (int i = 0; i < LC + 20; i++) begin
      step();
      n_checks++;
      if (act_out() !== exp_out()) begin
        n_fail++;
        $display("FAIL pd_relock cyc %0d: got %b expected %b", i, act_out(), exp_out());
      end
    end
  endtask

  task automatic test_async_reset();
    #2;
    nrst = 1'b0;
    #1;
    n_checks++;
    if (act_out() !== '0) begin
      n_fail++;
      $display("FAIL async_reset: got %b expected %b", act_out(), {(2*CN+1){1'b0}});
    end
    @(negedge clk);
    @(negedge clk);
    nrst = 1'b1;
    model_reset();
    for (int i = 0; i < LC + 20; i++) begin
      step();
      n_checks++;
      if (act_out() !== exp_out()) begin
        n_fail++;
        $display("FAIL reset_relock cyc %0d: got %b expected %b", i, act_out(), exp_out());
      end
    end
  endtask

  task automatic test_random_relock();
    logic [CN*DW-1:0] d;
    int hold;
    for (int it = 0; it < 8; it++) begin
      d = CN*DW'(0);
      for (int k = 0; k < CN; k++) d[k*DW +: DW] = DW'($urandom_range(0, 12));
      bus.i_div = d;
      if ($urandom_range(0, 1) == 1) begin
        bus.i_div_upd = 1'b1;
        step();
        bus.i_div_upd = 1'b0;
      end else begin
        hold = $urandom_range(1, 5);
        bus.i_pd = 1'b1;
        repeat (hold) step();
        bus.i_pd = 1'b0;
      end
      for (int i = 0; i < LC + 40; i++) begin
        step();
        n_checks++;
        if (act_out() !== exp_out()) begin
          n_fail++;
          $display("FAIL rand_relock it %0d cyc %0d: got %b expected %b", it, i, act_out(), exp_out());
        end
      end
    end
  endtask

  task automatic test_random_div_locked();
    int sel [CN];
    int last [CN];
    logic [CN*DW-1:0] d;
    d = CN*DW'(0);
    for (int k = 0; k < CN; k++) begin
      sel[k] = $urandom_range(0, 9);
      d[k*DW +: DW] = DW'(sel[k]);
      if (sel[k] == 0) sel[k] = 1;
      last[k] = -1;
    end
    bus.i_div = d;
    bus.i_div_upd = 1'b1;
    step();
    bus.i_div_upd = 1'b0;
    repeat (LC) step();
    for (int i = 0; i < 1000; i++) begin
      bus.i_div = CN*DW'($urandom);
      step();
      n_checks++;
      if (act_out() !== exp_out()) begin
        n_fail++;
        $display("FAIL rand_div cyc %0d: got %b expected %b", i, act_out(), exp_out());
      end
      for (int k = 0; k < CN; k++) begin
        if (bus.o_clk_en[k] === 1'b1) begin
          if (last[k] >= 0) begin
            n_checks++;
            if (i - last[k] != sel[k]) begin
              n_fail++;
              $display("FAIL strobe_spacing ch%0d cyc %0d: got %0d expected %0d", k, i, i - last[k], sel[k]);
            end
          end
          last[k] = i;
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_lock_basic();
    test_div_zero_max();
    test_div_upd();
    test_pd_and_upd();
    test_async_reset();
    test_random_relock();
    test_random_div_locked();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
